// File: rtl/iobus_uart_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state type for iobus_uart_tx.
// Build option IOBUS_UART_TX_PARITY_EN adds the even-parity state to tx_state_t.
package iobus_uart_pkg;

    localparam logic [31:0] TXDATA_OFS  = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS  = 32'h0000_0004;
    localparam logic [31:0] DIVISOR_OFS = 32'h0000_0008;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

    // A one-clock bit would leave no room for the counter reload cycle.
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef IOBUS_UART_TX_PARITY_EN
        ST_PAR,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/iobus_fifo.sv
// Generic synchronous FIFO with a combinational head (pop_dat shows the oldest entry).
// Latency: push at edge N is visible at the head and in count right after N.
// Backpressure: push while full and pop while empty are ignored; callers watch full/empty.
module iobus_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are exactly log2(DEPTH) bits so they wrap modulo depth for free.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped UART transmitter (TXDATA/STATUS/DIVISOR); IOBUS_UART_TX_PARITY_EN adds even parity.
// Latency: a byte written at edge N while idle drives its start bit from edge N+1; frames run gap-free.
// Backpressure: none on the bus; writes into a full FIFO are dropped and flagged in STATUS.ovf.
module iobus_uart_tx
    import iobus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        TX_IDLE
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel_txdata;
    logic          sel_status;
    logic          sel_divisor;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic          ovf;
    logic [15:0]   div_reg;

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [15:0]   cnt;
    logic [15:0]   cnt_nxt;
    logic [15:0]   act_div;
    logic [15:0]   act_div_nxt;
    logic [2:0]    idx;
    logic [2:0]    idx_nxt;
    logic [7:0]    shift;
    logic [7:0]    shift_nxt;
    logic          expire;
    logic          tx_nxt;
    logic          unused_wdat;

`ifdef IOBUS_UART_TX_PARITY_EN
    logic          par_bit;
    logic          par_nxt;
`endif

    assign sel_txdata  = (IOBUS_ADDR == BASE_ADDR + TXDATA_OFS);
    assign sel_status  = (IOBUS_ADDR == BASE_ADDR + STATUS_OFS);
    assign sel_divisor = (IOBUS_ADDR == BASE_ADDR + DIVISOR_OFS);
    assign push        = IOBUS_WR && sel_txdata;
    assign unused_wdat = ^IOBUS_OUT[31:16];

    iobus_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .push     (push),
        .push_dat (IOBUS_OUT[7:0]),
        .pop      (pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovf     <= 1'b0;
            div_reg <= DIV_RESET;
        end else begin
            if (push && fifo_full) begin
                ovf <= 1'b1;
            end else if (IOBUS_WR && sel_status && IOBUS_OUT[STAT_OVF]) begin
                ovf <= 1'b0;
            end
            if (IOBUS_WR && sel_divisor) begin
                div_reg <= (IOBUS_OUT[15:0] < DIV_MIN) ? DIV_MIN : IOBUS_OUT[15:0];
            end
        end
    end

    assign TX_IDLE = fifo_empty && (state == ST_IDLE);

    always_comb begin
        IOBUS_IN = '0;
        if (sel_status) begin
            IOBUS_IN[STAT_BUSY]            = ~TX_IDLE;
            IOBUS_IN[STAT_FULL]            = fifo_full;
            IOBUS_IN[STAT_EMPTY]           = fifo_empty;
            IOBUS_IN[STAT_OVF]             = ovf;
            IOBUS_IN[STAT_CNT_LSB +: CW]   = fifo_count;
        end else if (sel_divisor) begin
            IOBUS_IN[15:0] = div_reg;
        end
    end

    assign expire = (cnt == 16'd0);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        act_div_nxt = act_div;
        idx_nxt     = idx;
        shift_nxt   = shift;
        pop         = 1'b0;
`ifdef IOBUS_UART_TX_PARITY_EN
        par_nxt     = par_bit;
`endif
        if (state != ST_IDLE) begin
            cnt_nxt = expire ? (act_div - 16'd1) : (cnt - 16'd1);
        end

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (expire) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (expire) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef IOBUS_UART_TX_PARITY_EN
                        state_nxt = ST_PAR;
`else
                        state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef IOBUS_UART_TX_PARITY_EN
            ST_PAR: begin
                if (expire) begin
                    state_nxt = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (expire) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_START;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Divisor is latched per frame so software rewrites only affect later frames.
        if (pop) begin
            shift_nxt   = fifo_head;
            act_div_nxt = div_reg;
            cnt_nxt     = div_reg - 16'd1;
            idx_nxt     = 3'd0;
`ifdef IOBUS_UART_TX_PARITY_EN
            par_nxt     = ^fifo_head;
`endif
        end

        case (state_nxt)
            ST_START: tx_nxt = 1'b0;
            ST_DATA:  tx_nxt = shift_nxt[0];
`ifdef IOBUS_UART_TX_PARITY_EN
            ST_PAR:   tx_nxt = par_nxt;
`endif
            default:  tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            act_div <= DIV_RESET;
            idx     <= '0;
            shift   <= '0;
            TX      <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            act_div <= act_div_nxt;
            idx     <= idx_nxt;
            shift   <= shift_nxt;
            TX      <= tx_nxt;
        end
    end

`ifdef IOBUS_UART_TX_PARITY_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            par_bit <= 1'b0;
        end else begin
            par_bit <= par_nxt;
        end
    end
`endif

endmodule
